// File: rtl/painterengine_gpu_dma_reader.sv
// DMA read engine: turns (address, length) requests into 4 KB-safe AXI4
// INCR read bursts and streams the returned words to the display FIFO.
module painterengine_gpu_dma_reader #(
  parameter int unsigned MAX_BURST  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_wire_clock,
  input  logic                  i_wire_resetn,
  input  logic                  i_wire_reader_resetn,
  input  logic [31:0]           i_wire_reader_address,
  input  logic [31:0]           i_wire_reader_length,
  output logic                  o_wire_reader_done,
  output logic                  o_wire_reader_error,
  output logic [31:0]           o_wire_reader_data,
  output logic                  o_wire_reader_data_valid,
  input  logic                  i_wire_reader_data_next,
  output logic [ADDR_WIDTH-1:0] o_wire_m_axi_araddr,
  output logic [7:0]            o_wire_m_axi_arlen,
  output logic [2:0]            o_wire_m_axi_arsize,
  output logic [1:0]            o_wire_m_axi_arburst,
  output logic                  o_wire_m_axi_arvalid,
  input  logic                  i_wire_m_axi_arready,
  input  logic [31:0]           i_wire_m_axi_rdata,
  input  logic [1:0]            i_wire_m_axi_rresp,
  input  logic                  i_wire_m_axi_rlast,
  input  logic                  i_wire_m_axi_rvalid,
  output logic                  o_wire_m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AR, S_DATA, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]           remaining_q, remaining_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [8:0]            beat_q, beat_d;
  logic                  abort_q, abort_d;      // request dropped while AR was pending
  logic                  drain_err_q, drain_err_d;
  logic [31:0]           page_words;
  logic [31:0]           burst_words;
  logic [8:0]            beats;
  logic                  accept;
  logic                  last_idx;

  assign beats      = {1'b0, arlen_q} + 9'd1;
  assign page_words = {19'd0, 13'(13'h1000 - {1'b0, addr_q[11:0]})} >> 2;
  assign accept     = i_wire_m_axi_rvalid & i_wire_reader_data_next;
  assign last_idx   = (beat_q == {1'b0, arlen_q});

  assign o_wire_m_axi_arsize      = 3'b010;
  assign o_wire_m_axi_arburst     = 2'b01;
  assign o_wire_m_axi_araddr      = araddr_q;
  assign o_wire_m_axi_arlen       = arlen_q;
  assign o_wire_m_axi_arvalid     = (state_q == S_AR);
  assign o_wire_m_axi_rready      = (state_q == S_DRAIN) |
                                    ((state_q == S_DATA) & i_wire_reader_data_next);
  assign o_wire_reader_data_valid = (state_q == S_DATA) & accept;
  assign o_wire_reader_data       = (state_q == S_DATA) ? i_wire_m_axi_rdata : '0;
  assign o_wire_reader_done       = (state_q == S_DONE);
  assign o_wire_reader_error      = (state_q == S_ERROR);

  // Burst size: min(remaining, MAX_BURST, words left in this 4 KB page)
  always_comb begin
    burst_words = remaining_q;
    if (burst_words > MAX_BURST)  burst_words = MAX_BURST;
    if (burst_words > page_words) burst_words = page_words;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    araddr_d    = araddr_q;
    remaining_d = remaining_q;
    arlen_d     = arlen_q;
    beat_d      = beat_q;
    abort_d     = abort_q;
    drain_err_d = drain_err_q;
    case (state_q)
      S_IDLE: begin
        abort_d     = 1'b0;
        drain_err_d = 1'b0;
        if (i_wire_reader_resetn) begin
          addr_d      = ADDR_WIDTH'(i_wire_reader_address);
          remaining_d = i_wire_reader_length;
          if (i_wire_reader_address[1:0] != 2'b00) state_d = S_ERROR;
          else if (i_wire_reader_length == 32'd0)  state_d = S_DONE;
          else                                     state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!i_wire_reader_resetn) begin
          state_d = S_IDLE;
        end else begin
          araddr_d = addr_q;
          arlen_d  = 8'(burst_words - 32'd1);
          beat_d   = '0;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        if (!i_wire_reader_resetn) abort_d = 1'b1;
        if (i_wire_m_axi_arready)
          state_d = (abort_q || !i_wire_reader_resetn) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (accept) begin
          if (!i_wire_reader_resetn) begin
            // Beat just taken may already close the burst; nothing left to drain then.
            state_d = i_wire_m_axi_rlast ? S_IDLE : S_DRAIN;
          end else if (i_wire_m_axi_rresp != 2'b00) begin
            state_d = S_ERROR;
          end else if (i_wire_m_axi_rlast && !last_idx) begin
            // Early rlast already ended the burst, so the drain step is empty.
            state_d = S_ERROR;
          end else if (!i_wire_m_axi_rlast && last_idx) begin
            drain_err_d = 1'b1;
            state_d     = S_DRAIN;
          end else if (last_idx) begin
            addr_d      = addr_q + ADDR_WIDTH'({beats, 2'b00});
            remaining_d = remaining_q - {23'd0, beats};
            state_d     = (remaining_q == {23'd0, beats}) ? S_DONE : S_CALC;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end else if (!i_wire_reader_resetn) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_wire_m_axi_rvalid && i_wire_m_axi_rlast)
          state_d = drain_err_q ? S_ERROR : S_IDLE;
      end
      S_DONE, S_ERROR: begin
        if (!i_wire_reader_resetn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      araddr_q    <= '0;
      remaining_q <= '0;
      arlen_q     <= '0;
      beat_q      <= '0;
      abort_q     <= 1'b0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      araddr_q    <= araddr_d;
      remaining_q <= remaining_d;
      arlen_q     <= arlen_d;
      beat_q      <= beat_d;
      abort_q     <= abort_d;
      drain_err_q <= drain_err_d;
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Self-checking bench: AXI read slave model, burst-splitting reference
// model feeding AR/data scoreboards, table of requests plus corner cases.
module tb_painterengine_gpu_dma_reader;

  localparam int unsigned MAXB = 32;

  logic        clk, resetn, rd_resetn;
  logic [31:0] rd_addr, rd_len;
  logic        done, error, data_valid, data_next;
  logic [31:0] data;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;

  painterengine_gpu_dma_reader #(.MAX_BURST(MAXB), .ADDR_WIDTH(32)) dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn),
    .i_wire_reader_resetn(rd_resetn), .i_wire_reader_address(rd_addr),
    .i_wire_reader_length(rd_len), .o_wire_reader_done(done),
    .o_wire_reader_error(error), .o_wire_reader_data(data),
    .o_wire_reader_data_valid(data_valid), .i_wire_reader_data_next(data_next),
    .o_wire_m_axi_araddr(araddr), .o_wire_m_axi_arlen(arlen),
    .o_wire_m_axi_arsize(arsize), .o_wire_m_axi_arburst(arburst),
    .o_wire_m_axi_arvalid(arvalid), .i_wire_m_axi_arready(arready),
    .i_wire_m_axi_rdata(rdata), .i_wire_m_axi_rresp(rresp),
    .i_wire_m_axi_rlast(rlast), .i_wire_m_axi_rvalid(rvalid),
    .o_wire_m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct {
    logic [31:0] addr; logic [31:0] len; int mode;
    logic exp_done; logic exp_err; int unsigned exp_ars;
  } vec_t;

  int unsigned n_cmp = 0, n_bad = 0;
  ar_t         exp_ar[$];
  logic [31:0] exp_data[$];
  ar_t         pend[$];

  // knobs written by the main sequence
  int next_mode = 0;    // 0: always ready, 1: toggle, 2: random
  int err_beat  = -1;   // absolute slave beat number that returns SLVERR
  bit abort_mode = 1'b0;
  bit flush      = 1'b0;

  // state owned by the bus process
  int unsigned cyc = 0, ar_count = 0, valid_count = 0, last_valid_cyc = 0;
  int unsigned beat_g = 0, idx = 0, blen = 0;
  logic [31:0] base = '0;
  bit act = 1'b0, slave_busy = 1'b0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference model: split a request into page-safe bursts, queue ARs and data
  task automatic model_push(input logic [31:0] a0, input logic [31:0] l);
    logic [31:0] a, rem, b, pg;
    a = a0; rem = l;
    if (a0[1:0] != 2'b00) return;
    while (rem != 0) begin
      pg = (32'd4096 - {20'd0, a[11:0]}) >> 2;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > pg)   b = pg;
      exp_ar.push_back('{a, 8'(b - 1)});
      for (int unsigned i = 0; i < b; i++) exp_data.push_back(pat(a + 4 * i));
      a = a + b * 4;
      rem = rem - b;
    end
  endtask

  // Bus process: consumer readiness, AXI slave, output monitor
  initial begin
    ar_t e, b;
    bit ar_fire, r_fire;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; data_next = 1'b0;
    forever begin
      @(negedge clk);
      case (next_mode)
        0:       data_next = 1'b1;
        1:       data_next = ~data_next;
        default: data_next = 1'($urandom_range(0, 1));
      endcase
      #1;
      cyc++;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (ar_fire) begin
        ar_count++;
        if (exp_ar.size() == 0) fail_now("unexpected_ar");
        else begin
          e = exp_ar.pop_front();
          check("araddr", araddr, e.addr);
          check("arlen", arlen, e.len);
        end
        pend.push_back('{araddr, arlen});
      end
      if (rvalid && next_mode == 1) check("rready_follows_next", rready, data_next);
      if (rvalid && !abort_mode)    check("valid_eq_accept", data_valid, r_fire);
      if (rvalid && abort_mode)     check("drain_ready_novalid", {rready, data_valid}, 2'b10);
      if (data_valid) begin
        valid_count++;
        last_valid_cyc = cyc;
        if (exp_data.size() == 0) fail_now("unexpected_beat");
        else check("rdata_stream", data, exp_data.pop_front());
      end
      @(posedge clk);
      #1;
      if (flush) begin
        pend.delete();
        act = 1'b0;
      end else begin
        if (r_fire && act) begin
          beat_g++;
          if (idx == blen) act = 1'b0;
          else idx++;
        end
        if (!act && pend.size() != 0) begin
          b = pend.pop_front();
          act = 1'b1; base = b.addr; blen = b.len; idx = 0;
        end
      end
      slave_busy = act || (pend.size() != 0);
      rvalid  = act;
      rdata   = act ? pat(base + 4 * idx) : '0;
      rlast   = act && (idx == blen);
      rresp   = (act && int'(beat_g) == err_beat) ? 2'b10 : 2'b00;
      arready = (next_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_end(input int unsigned budget, output bit timed_out);
    timed_out = 1'b1;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (done || error) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned ar0, vc0, c0;
    bit to;
    ar0 = ar_count; vc0 = valid_count;
    next_mode = v.mode;
    model_push(v.addr, v.len);
    @(negedge clk);
    rd_addr = v.addr; rd_len = v.len; rd_resetn = 1'b1;
    c0 = cyc;
    wait_end(3000, to);
    if (to) fail_now({tag, "_timeout"});
    else begin
      check({tag, "_done_error"}, {done, error}, {v.exp_done, v.exp_err});
      if (v.exp_done && v.len != 0) check({tag, "_done_latency"}, cyc - last_valid_cyc, 1);
      if (v.len == 0) check({tag, "_len0_within2"}, (cyc - c0) <= 2, 1);
    end
    check({tag, "_ar_count"}, ar_count - ar0, v.exp_ars);
    check({tag, "_beats"}, valid_count - vc0, v.exp_done ? v.len : 0);
    check({tag, "_data_left"}, exp_data.size(), 0);
    repeat (3) @(negedge clk);
    #2 check({tag, "_held"}, {done, error}, {v.exp_done, v.exp_err});
    @(negedge clk); rd_resetn = 1'b0;
    @(negedge clk); #2 check({tag, "_cleared"}, {done, error}, 2'b00);
    exp_data.delete(); exp_ar.delete();
    next_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int unsigned ar0, vc0;
    bit to;
    vecs[0] = '{32'h1000_0000, 32'd20,  0, 1'b1, 1'b0, 1};
    vecs[1] = '{32'h0000_0FC0, 32'd40,  0, 1'b1, 1'b0, 2};
    vecs[2] = '{32'h2000_0000, 32'd32,  1, 1'b1, 1'b0, 1};
    vecs[3] = '{32'h0000_1002, 32'd4,   0, 1'b0, 1'b1, 0};
    vecs[4] = '{32'h0000_3000, 32'd0,   0, 1'b1, 1'b0, 0};
    vecs[5] = '{32'h0000_0FFC, 32'd1,   0, 1'b1, 1'b0, 1};
    vecs[6] = '{32'h0000_0FF8, 32'd5,   1, 1'b1, 1'b0, 2};
    vecs[7] = '{32'h4000_0000, 32'd100, 2, 1'b1, 1'b0, 4};
    vecs[8] = '{32'hFFFF_FFF0, 32'd8,   0, 1'b1, 1'b0, 2};

    resetn = 1'b0; rd_resetn = 1'b0; rd_addr = '0; rd_len = '0;
    repeat (2) @(negedge clk);
    #2;
    check("reset_ctrl", {done, error, data_valid, arvalid, rready, arsize, arburst},
          {5'b00000, 3'b010, 2'b01});
    check("reset_ar", {araddr, arlen}, 40'h0);
    check("reset_data", data, 32'h0);
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // SLVERR on the fifth of eight beats
    ar0 = ar_count; vc0 = valid_count;
    err_beat = int'(beat_g) + 4;
    model_push(32'h6000_0000, 32'd8);
    @(negedge clk); rd_addr = 32'h6000_0000; rd_len = 32'd8; rd_resetn = 1'b1;
    wait_end(500, to);
    if (to) fail_now("rresp_timeout");
    else begin
      check("rresp_done_error", {done, error}, 2'b01);
      check("rresp_latency", cyc - last_valid_cyc, 1);
    end
    check("rresp_beats", valid_count - vc0, 5);
    flush = 1'b1; exp_data.delete(); exp_ar.delete();
    repeat (2) @(negedge clk);
    #2 check("rresp_error_held", {done, error}, 2'b01);
    rd_resetn = 1'b0;
    repeat (2) @(negedge clk);
    #2 check("rresp_error_cleared", error, 1'b0);
    flush = 1'b0; err_beat = -1;

    // Request dropped after three of sixteen beats, then a fresh request
    vc0 = valid_count;
    model_push(32'h5000_0000, 32'd16);
    @(negedge clk); rd_addr = 32'h5000_0000; rd_len = 32'd16; rd_resetn = 1'b1;
    to = 1'b1;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (valid_count - vc0 >= 3) begin to = 1'b0; break; end
    end
    if (to) fail_now("drop_no_beats");
    rd_resetn = 1'b0; abort_mode = 1'b1;
    to = 1'b1;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (!slave_busy) begin to = 1'b0; break; end
    end
    if (to) fail_now("drop_drain_timeout");
    repeat (2) @(negedge clk);
    #2;
    check("drop_beats", valid_count - vc0, 3);
    check("drop_idle_outputs", {done, error, arvalid, rready}, 4'b0000);
    abort_mode = 1'b0; exp_data.delete(); exp_ar.delete();
    run_vec('{32'h5000_1000, 32'd4, 0, 1'b1, 1'b0, 1}, "after_drop");

    // Asynchronous reset in the middle of a burst
    model_push(32'h7000_0000, 32'd16);
    vc0 = valid_count;
    @(negedge clk); rd_addr = 32'h7000_0000; rd_len = 32'd16; rd_resetn = 1'b1;
    to = 1'b1;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (valid_count - vc0 >= 2) begin to = 1'b0; break; end
    end
    if (to) fail_now("async_no_beats");
    #1 resetn = 1'b0; rd_resetn = 1'b0; flush = 1'b1;
    #1 check("async_reset_outputs", {done, error, arvalid, rready, data_valid, araddr, arlen},
             {5'b00000, 32'h0, 8'h0});
    repeat (2) @(negedge clk);
    resetn = 1'b1; flush = 1'b0; exp_data.delete(); exp_ar.delete();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
